imem_arbiter: RTL
=================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, ROM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, ROM word width.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have ports req_valid_i[p], input, 1, requester p has a read request, for p = 0 (instruction fetch) and p = 1 (debug/data read).
REQ-006 The block SHALL have ports req_addr_i[p], input, ADDR_WIDTH, word address of the request.
REQ-007 The block SHALL have ports req_ready_o[p], output, 1, request accepted (granted) this cycle.
REQ-008 The block SHALL have ports rsp_valid_o[p], output, 1, read data for p is presented.
REQ-009 The block SHALL have ports rsp_data_o[p], output, DATA_WIDTH, read data.
REQ-010 The block SHALL have ports rsp_ready_i[p], input, 1, requester p consumes the response this cycle.
REQ-011 The block SHALL have port rom_addr_o, output, ADDR_WIDTH, address driven to the synchronous ROM.
REQ-012 The block SHALL have port rom_data_i, input, DATA_WIDTH, ROM data, valid one cycle after the address.

Function
REQ-013 A request SHALL transfer when req_valid_i[p] and req_ready_o[p] are both high; a response SHALL transfer when rsp_valid_o[p] and rsp_ready_i[p] are both high.
REQ-014 The block SHALL grant at most one request per cycle and SHALL drive rom_addr_o combinationally from the granted req_addr_i; with no grant, rom_addr_o SHALL hold the last granted address.
REQ-015 Port p SHALL be eligible only when hold[p] is empty and NOT (inflight to p AND rsp_ready_i[p] low).
REQ-016 Arbitration SHALL be round-robin between eligible requesting ports; the port not granted last SHALL win a tie; a lone eligible requester SHALL win every cycle.
REQ-017 On a grant, the block SHALL register inflight_valid = 1 and inflight_port = p; otherwise it SHALL register inflight_valid = 0.
REQ-018 Read latency SHALL be exactly 1 cycle: data for a request granted in cycle N SHALL appear on rsp_data_o[p] with rsp_valid_o[p] = 1 in cycle N+1 when hold[p] is empty.
REQ-019 If an inflight response arrives and rsp_ready_i[p] is low, the block SHALL capture rom_data_i into hold[p] (1 entry) and present it until consumed.
REQ-020 When hold[p] is full, rsp_data_o[p] SHALL come from hold[p]; otherwise it SHALL come from rom_data_i; responses per port SHALL be in request order.
REQ-021 Sustained throughput SHALL be 1 read/cycle when one port requests with rsp_ready_i held high.
REQ-022 rsp_valid_o[p] SHALL NOT depend combinationally on rsp_ready_i[p]; req_ready_o[p] MAY depend on req_valid_i and rsp_ready_i.
REQ-023 When both ports request on the same cycle a hold entry drains, the drained port SHALL be eligible from the next cycle only.

Reset
REQ-024 While rst_i is high, the block SHALL keep inflight_valid = 0, both hold entries empty, the round-robin pointer favouring port 0, rom_addr_o = 0, and all rsp_valid_o = 0.
REQ-025 Assertion of rst_i mid-transaction SHALL discard inflight and held data; no response SHALL be presented for requests accepted before reset.

Structure
REQ-026 A shared package imem_pkg SHALL hold the port-index enum (PORT_FETCH = 0, PORT_DBG = 1), NUM_PORTS = 2, and the default widths.
REQ-027 The per-port hold register and its valid flag SHALL be one sub-module, imem_rsp_hold, instantiated once per port.

Verification
REQ-028 The bench SHALL cover this scenario: single fetch, port 0 addr 0x05 with ROM[5] = 0xDEADBEEF -> rsp_valid_o[0] = 1 next cycle, data 0xDEADBEEF.
REQ-029 The bench SHALL cover this scenario: both ports request every cycle with both ready -> grants alternate 0,1,0,1, starting with port 0 after reset.
REQ-030 The bench SHALL cover this scenario: port 1 reads 0x10 and holds rsp_ready_i[1] low for 3 cycles -> data held stable, port 1 not granted, and port 0 still granted each cycle.
REQ-031 The bench SHALL cover this scenario: port 0 streams addr 0..7 with ready high -> 8 responses in 8 consecutive cycles, in order.
REQ-032 The bench SHALL cover this scenario: rst_i asserted with inflight and hold full -> all rsp_valid_o low immediately and no stale response after release.
REQ-033 The bench SHALL cover this scenario: addr 0xFF (top word) -> correct ROM[255] returned with no wrap artefact.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the two-port instruction-memory read arbiter.
// Port indices, port count and default ROM geometry.
package imem_pkg;

    localparam int NUM_PORTS      = 2;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DBG   = 1'b1
    } port_e;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_FETCH) ? PORT_DBG : PORT_FETCH;
    endfunction

endpackage

// File: rtl/imem_rsp_hold.sv
// One-entry skid register for a response that arrived while its requester stalled.
// Capture and release are mutually exclusive by construction in the arbiter.
module imem_rsp_hold #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_capture,
    input  logic                  i_release,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_release) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between instruction fetch and debug reads.
// One grant per cycle, 1-cycle read latency, per-port hold entry absorbs response back-pressure.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_PORTS-1:0]                  req_valid_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr_i,
    output logic [NUM_PORTS-1:0]                  req_ready_o,
    output logic [NUM_PORTS-1:0]                  rsp_valid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rsp_data_o,
    input  logic [NUM_PORTS-1:0]                  rsp_ready_i,
    output logic [ADDR_WIDTH-1:0]                 rom_addr_o,
    input  logic [DATA_WIDTH-1:0]                 rom_data_i
);

    logic                  r_inflight_valid;
    port_e                 r_inflight_port;
    port_e                 r_last_port;
    logic [ADDR_WIDTH-1:0] r_rom_addr;

    logic [NUM_PORTS-1:0]                 w_inflight_to;
    logic [NUM_PORTS-1:0]                 w_hold_valid;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_hold_data;
    logic [NUM_PORTS-1:0]                 w_elig;
    logic [NUM_PORTS-1:0]                 w_capture;
    logic [NUM_PORTS-1:0]                 w_release;
    logic [NUM_PORTS-1:0]                 w_cand;
    logic [NUM_PORTS-1:0]                 w_grant;
    logic                                 w_any_grant;
    port_e                                w_gnt_port;

    assign w_inflight_to = r_inflight_valid ? (NUM_PORTS'(1) << r_inflight_port) : '0;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        // A port with a response it cannot take next cycle must not issue another read.
        assign w_elig[p]    = !w_hold_valid[p] && !(w_inflight_to[p] && !rsp_ready_i[p]);
        assign w_capture[p] = w_inflight_to[p] && !rsp_ready_i[p];
        assign w_release[p] = w_hold_valid[p] && rsp_ready_i[p];

        imem_rsp_hold #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_hold (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .i_capture (w_capture[p]),
            .i_release (w_release[p]),
            .i_data    (rom_data_i),
            .o_valid   (w_hold_valid[p]),
            .o_data    (w_hold_data[p])
        );

        assign rsp_valid_o[p] = w_hold_valid[p] || w_inflight_to[p];
        assign rsp_data_o[p]  = w_hold_valid[p] ? w_hold_data[p] : rom_data_i;
    end

    // Grants are suppressed during reset so the ROM address stays at zero.
    always_comb begin
        w_cand      = req_valid_i & w_elig & {NUM_PORTS{!rst_i}};
        w_any_grant = |w_cand;
        if (&w_cand)
            w_gnt_port = other_port(r_last_port);
        else if (w_cand[PORT_DBG])
            w_gnt_port = PORT_DBG;
        else
            w_gnt_port = PORT_FETCH;
        w_grant = w_any_grant ? (NUM_PORTS'(1) << w_gnt_port) : '0;
    end

    assign req_ready_o = w_grant;
    assign rom_addr_o  = w_any_grant ? req_addr_i[w_gnt_port] : r_rom_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inflight_valid <= 1'b0;
            r_inflight_port  <= PORT_FETCH;
            r_last_port      <= PORT_DBG;
            r_rom_addr       <= '0;
        end else begin
            r_inflight_valid <= w_any_grant;
            if (w_any_grant) begin
                r_inflight_port <= w_gnt_port;
                r_last_port     <= w_gnt_port;
                r_rom_addr      <= rom_addr_o;
            end
        end
    end

endmodule
